serial_subtractor: RTL and testbench

Bit-serial N-bit unsigned subtractor with a borrow chain. It computes D = A − B − Bi one bit per clock, LSB first, through a single borrow flip-flop. Operands enter on a valid/ready handshake, and the result leaves on a valid/ready handshake. It is the area-lean inverse companion to the team's parallel adder, meant for datapaths where N cycles of latency are acceptable in exchange for one full-subtractor cell.

---
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result handshake bundle for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         Bo;
    logic         busy;

    modport master (
        output in_valid, A, B, Bi, out_ready,
        input  in_ready, out_valid, D, Bo, busy
    );

    modport slave (
        input  in_valid, A, B, Bi, out_ready,
        output in_ready, out_valid, D, Bo, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit unsigned subtractor, LSB first, one borrow FF.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int                   c_CNT_W = $clog2(N + 1);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(N - 1);
    localparam logic [1:0]           c_IDLE  = 2'd0;
    localparam logic [1:0]           c_RUN   = 2'd1;
    localparam logic [1:0]           c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_d;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_bit;
    logic               w_borrow_nxt;
    logic [N-1:0]       w_d_shift;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    // Full-subtractor cell operating on the current LSBs
    assign w_bit        = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

    generate
        if (N == 1) begin : g_shift_single
            assign w_d_shift = w_bit;
        end else begin : g_shift_multi
            assign w_d_shift = {w_bit, r_d[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)     w_next = c_RUN;
            c_RUN:   if (r_cnt == c_LAST)  w_next = c_DONE;
            c_DONE:  if (bus.out_ready)    w_next = c_IDLE;
            default:                       w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == c_IDLE);
        w_busy      = (r_state == c_RUN);
        w_out_valid = (r_state == c_DONE);
    end

    // D and borrow only move during RUN, so they hold through DONE and IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == c_IDLE && bus.in_valid) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= bus.Bi;
            r_cnt    <= '0;
        end else if (r_state == c_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_d      <= w_d_shift;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.D         = r_d;
    assign bus.Bo        = r_borrow;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed checks of serial_subtractor at N=4, plus N=1 and N=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   compared;
    int   failed;

    serial_subtractor_if #(.N(4)) if4 ();
    serial_subtractor_if #(.N(1)) if1 ();
    serial_subtractor_if #(.N(8)) if8 ();

    serial_subtractor #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    serial_subtractor #(.N(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    serial_subtractor #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        #3;
        compared++; if (if4.in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", if4.in_ready); end
        compared++; if (if4.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", if4.busy); end
        compared++; if (if4.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); end
        compared++; if (if4.D !== 4'd0 || if4.Bo !== 1'b0) begin failed++; $display("FAIL reset_d_bo: got D=%0d Bo=%b want 0/0", if4.D, if4.Bo); end
        compared++; if (if8.D !== 8'd0 || if1.out_valid !== 1'b0) begin failed++; $display("FAIL reset_n8_n1: got D8=%0d ov1=%b want 0/0", if8.D, if1.out_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One N=4 transaction with out_ready high; checks latency, busy length, result, hold in IDLE
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          input logic [3:0] exp_d, input logic exp_bo, input string name);
        int k;
        int busy_cnt;
        @(negedge clk);
        if4.A = a; if4.B = b; if4.Bi = bi; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        compared++; if (if4.in_ready !== 1'b1) begin failed++; $display("FAIL %s_in_ready: got %b want 1", name, if4.in_ready); end
        @(negedge clk);
        if4.in_valid = 1'b0;
        if4.A = ~a; if4.B = ~b; if4.Bi = ~bi;
        k = 1;
        busy_cnt = 0;
        while (if4.out_valid !== 1'b1 && k < 40) begin
            if (if4.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            k++;
        end
        compared++; if (k != 5) begin failed++; $display("FAIL %s_latency: got %0d want 5", name, k); end
        compared++; if (busy_cnt != 4) begin failed++; $display("FAIL %s_busy_len: got %0d want 4", name, busy_cnt); end
        compared++; if (if4.D !== exp_d || if4.Bo !== exp_bo) begin failed++; $display("FAIL %s_result: got D=%0d Bo=%b want D=%0d Bo=%b", name, if4.D, if4.Bo, exp_d, exp_bo); end
        @(negedge clk);
        compared++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1 || if4.D !== exp_d) begin failed++; $display("FAIL %s_after: got ov=%b ir=%b D=%0d want 0/1/%0d", name, if4.out_valid, if4.in_ready, if4.D, exp_d); end
    endtask

    task automatic test_basic();
        do_op4(4'd5,  4'd3,  1'b0, 4'd2,  1'b0, "sub_5_3");
        do_op4(4'd3,  4'd5,  1'b0, 4'd14, 1'b1, "sub_3_5");
        do_op4(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, "sub_0_0_bi");
        do_op4(4'd15, 4'd15, 1'b0, 4'd0,  1'b0, "sub_15_15");
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge clk);
        if4.A = 4'd9; if4.B = 4'd4; if4.Bi = 1'b1; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
        @(negedge clk);
        if4.in_valid = 1'b0;
        k = 0;
        while (if4.out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        compared++; if (if4.out_valid !== 1'b1) begin failed++; $display("FAIL bp_out_valid: got %b want 1", if4.out_valid); end
        for (int c = 0; c < 10; c++) begin
            if4.in_valid = c[0];
            @(negedge clk);
            compared++;
            if (if4.D !== 4'd4 || if4.Bo !== 1'b0 || if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1) begin
                failed++;
                $display("FAIL bp_hold_%0d: got D=%0d Bo=%b ir=%b ov=%b want 4/0/0/1", c, if4.D, if4.Bo, if4.in_ready, if4.out_valid);
            end
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(negedge clk);
        compared++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin failed++; $display("FAIL bp_release: got ir=%b ov=%b want 1/0", if4.in_ready, if4.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] av [3];
        logic [3:0] bv [3];
        logic       biv [3];
        logic [3:0] ed [3];
        logic       eb [3];
        int         acc_t [3];
        int         idx;
        int         nres;
        av = '{4'd7, 4'd2, 4'd8}; bv = '{4'd2, 4'd7, 4'd8}; biv = '{1'b0, 1'b1, 1'b1};
        ed = '{4'd5, 4'd10, 4'd15}; eb = '{1'b0, 1'b1, 1'b1};
        acc_t = '{0, 0, 0};
        idx = 0;
        nres = 0;
        @(negedge clk);
        if4.out_ready = 1'b1;
        for (int c = 0; c < 40 && nres < 3; c++) begin
            if (if4.out_valid === 1'b1) begin
                compared++;
                if (if4.D !== ed[nres] || if4.Bo !== eb[nres]) begin
                    failed++;
                    $display("FAIL b2b_result_%0d: got D=%0d Bo=%b want D=%0d Bo=%b", nres, if4.D, if4.Bo, ed[nres], eb[nres]);
                end
                nres++;
            end
            if (idx < 3) begin
                if4.A = av[idx]; if4.B = bv[idx]; if4.Bi = biv[idx];
                if4.in_valid = (if4.busy === 1'b1) ? c[0] : 1'b1;
            end else begin
                if4.in_valid = 1'b0;
            end
            if (idx < 3 && if4.in_ready === 1'b1 && if4.in_valid === 1'b1) begin
                acc_t[idx] = c;
                idx++;
            end
            @(negedge clk);
        end
        if4.in_valid = 1'b0;
        compared++; if (nres != 3) begin failed++; $display("FAIL b2b_count: got %0d want 3", nres); end
        compared++; if (acc_t[1] - acc_t[0] != 6) begin failed++; $display("FAIL b2b_spacing_01: got %0d want 6", acc_t[1] - acc_t[0]); end
        compared++; if (acc_t[2] - acc_t[1] != 6) begin failed++; $display("FAIL b2b_spacing_12: got %0d want 6", acc_t[2] - acc_t[1]); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic seen;
        @(negedge clk);
        if4.A = 4'd12; if4.B = 4'd7; if4.Bi = 1'b0; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        @(negedge clk);
        compared++; if (if4.busy !== 1'b1 || if4.D === 4'd0) begin failed++; $display("FAIL ares_midrun: got busy=%b D=%0d want busy=1 D!=0", if4.busy, if4.D); end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (if4.in_ready !== 1'b1 || if4.busy !== 1'b0 || if4.out_valid !== 1'b0 || if4.D !== 4'd0 || if4.Bo !== 1'b0) begin
            failed++;
            $display("FAIL ares_immediate: got ir=%b busy=%b ov=%b D=%0d Bo=%b want 1/0/0/0/0", if4.in_ready, if4.busy, if4.out_valid, if4.D, if4.Bo);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (if4.out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        compared++; if (seen !== 1'b0) begin failed++; $display("FAIL ares_no_out_valid: got %b want 0", seen); end
        do_op4(4'd12, 4'd7, 1'b0, 4'd5, 1'b0, "after_reset");
    endtask

    task automatic test_sweep_n1();
        int k;
        logic exp_d;
        logic exp_bo;
        for (int v = 0; v < 8; v++) begin
            exp_d  = v[2] ^ v[1] ^ v[0];
            exp_bo = (int'(v[2]) < int'(v[1]) + int'(v[0]));
            @(negedge clk);
            if1.A = v[2]; if1.B = v[1]; if1.Bi = v[0]; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
            @(negedge clk);
            if1.in_valid = 1'b0;
            k = 1;
            while (if1.out_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            compared++;
            if (k != 2 || if1.D !== exp_d || if1.Bo !== exp_bo) begin
                failed++;
                $display("FAIL n1_%0d: got lat=%0d D=%b Bo=%b want 2/%b/%b", v, k, if1.D, if1.Bo, exp_d, exp_bo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep_n8();
        int k;
        int a;
        int b;
        int bi;
        logic [7:0] exp_d;
        logic       exp_bo;
        for (int v = 0; v < 16; v++) begin
            if (v == 0)      begin a = 0;   b = 255; bi = 1; end
            else if (v == 1) begin a = 255; b = 0;   bi = 0; end
            else if (v == 2) begin a = 128; b = 128; bi = 1; end
            else begin
                a = int'($urandom_range(255)); b = int'($urandom_range(255)); bi = int'($urandom_range(1));
            end
            exp_d  = 8'((a - b - bi) & 255);
            exp_bo = (a < b + bi);
            @(negedge clk);
            if8.A = 8'(a); if8.B = 8'(b); if8.Bi = bi[0]; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
            @(negedge clk);
            if8.in_valid = 1'b0;
            k = 1;
            while (if8.out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
            compared++;
            if (k != 9 || if8.D !== exp_d || if8.Bo !== exp_bo) begin
                failed++;
                $display("FAIL n8_%0d: A=%0d B=%0d Bi=%0d got lat=%0d D=%0d Bo=%b want 9/%0d/%b", v, a, b, bi, k, if8.D, if8.Bo, exp_d, exp_bo);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.Bi = 1'b0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.A = '0; if1.B = '0; if1.Bi = 1'b0; if1.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.Bi = 1'b0; if8.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_sweep_n1();
        test_sweep_n8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
`default_nettype wire
